// File: rtl/wb_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : wb_cache_controller
// Purpose  : Direct-mapped, write-back, write-allocate cache controller placed
//            in front of a main memory with a combinational 4-word block port.
//            Hits are served from local line storage. A miss first writes
//            back the victim's dirty words, one beat per word, and then
//            refills the whole block in a single cycle.
// Ports    : clk, rst_n                 - clock, synchronous active-low reset
//            req_valid/req_ready        - CPU request handshake (ready in IDLE)
//            req_write/addr/wdata       - CPU request fields (10-bit word addr)
//            resp_valid/resp_rdata      - one-cycle completion pulse and data
//            isMemRead/isLock/address   - memory control and block address
//            writeData/isDirty          - memory write word and one-hot select
//            readData                   - memory block {w0,w1,w2,w3}
//            hit_count/miss_count       - wrapping first-compare statistics
// Revision : 1.0 - initial release
// ============================================================================
module wb_cache_controller #(
   parameter int LINES = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [9:0]       req_addr,
   input  logic [31:0]      req_wdata,
   output logic             resp_valid,
   output logic [31:0]      resp_rdata,
   output logic             isMemRead,
   output logic             isLock,
   output logic [9:0]       address,
   output logic [127:0]     writeData,
   output logic [3:0]       isDirty,
   input  logic [127:0]     readData,
   output logic [CNT_W-1:0] hit_count,
   output logic [CNT_W-1:0] miss_count
);

   localparam int IDX   = $clog2(LINES);
   localparam int TAG_W = 8 - IDX;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_COMPARE   = 3'd1;
   localparam logic [2:0] S_WRITEBACK = 3'd2;
   localparam logic [2:0] S_FILL      = 3'd3;
   localparam logic [2:0] S_RESP      = 3'd4;

   logic [2:0]       state;
   logic [2:0]       state_next;

   // Latched request
   logic             req_write_q;
   logic [9:0]       req_addr_q;
   logic [31:0]      req_wdata_q;
   // Set on accept, cleared by the first COMPARE so only that one is counted
   logic             first_cmp;

   // Line storage
   logic [LINES-1:0] line_valid;
   logic [TAG_W-1:0] line_tag   [LINES];
   logic [31:0]      line_data  [LINES][4];
   logic [3:0]       line_dirty [LINES];

   logic [TAG_W-1:0] req_tag;
   logic [IDX-1:0]   req_idx;
   logic [1:0]       req_off;
   logic             hit;
   logic [3:0]       victim_dirty;
   logic             victim_needs_wb;
   logic [1:0]       wb_word;
   logic [3:0]       wb_onehot;
   logic [3:0]       wb_remaining;

   assign req_tag = req_addr_q[9:2+IDX];
   assign req_idx = req_addr_q[1+IDX:2];
   assign req_off = req_addr_q[1:0];

   assign hit             = line_valid[req_idx] && (line_tag[req_idx] == req_tag);
   assign victim_dirty    = line_dirty[req_idx];
   assign victim_needs_wb = line_valid[req_idx] && (victim_dirty != 4'b0000);

   // Lowest set dirty bit is written first, giving ascending word order
   always_comb begin
      wb_word = 2'd0;
      if (victim_dirty[0])      wb_word = 2'd0;
      else if (victim_dirty[1]) wb_word = 2'd1;
      else if (victim_dirty[2]) wb_word = 2'd2;
      else if (victim_dirty[3]) wb_word = 2'd3;
   end

   assign wb_onehot    = 4'b0001 << wb_word;
   assign wb_remaining = victim_dirty & ~wb_onehot;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:      if (req_valid) state_next = S_COMPARE;
         S_COMPARE: begin
            if (hit)                  state_next = S_RESP;
            else if (victim_needs_wb) state_next = S_WRITEBACK;
            else                      state_next = S_FILL;
         end
         S_WRITEBACK: if (wb_remaining == 4'b0000) state_next = S_FILL;
         S_FILL:      state_next = S_COMPARE;
         S_RESP:      state_next = S_IDLE;
         default:     state_next = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Output decode: handshake and memory port from state and registers
   // ------------------------------------------------------------------
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      isLock     = 1'b1;
      isMemRead  = 1'b1;
      isDirty    = 4'b0000;
      address    = 10'd0;
      writeData  = 128'd0;
      case (state)
         S_IDLE: req_ready = 1'b1;
         S_RESP: resp_valid = 1'b1;
         S_WRITEBACK: begin
            isLock    = 1'b0;
            isMemRead = 1'b0;
            address   = {line_tag[req_idx], req_idx, 2'b00};
            isDirty   = wb_onehot;
            writeData = {4{line_data[req_idx][wb_word]}};
         end
         S_FILL: begin
            isLock  = 1'b0;
            address = {req_tag, req_idx, 2'b00};
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: request latch, line storage, response and counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         req_write_q <= 1'b0;
         req_addr_q  <= 10'd0;
         req_wdata_q <= 32'd0;
         first_cmp   <= 1'b0;
         line_valid  <= '0;
         for (int i = 0; i < LINES; i++) line_dirty[i] <= 4'b0000;
         resp_rdata  <= 32'd0;
         hit_count   <= '0;
         miss_count  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  req_write_q <= req_write;
                  req_addr_q  <= req_addr;
                  req_wdata_q <= req_wdata;
                  first_cmp   <= 1'b1;
               end
            end
            S_COMPARE: begin
               first_cmp <= 1'b0;
               if (first_cmp) begin
                  if (hit) hit_count  <= hit_count + CNT_W'(1);
                  else     miss_count <= miss_count + CNT_W'(1);
               end
               if (hit) begin
                  if (req_write_q) begin
                     line_data[req_idx][req_off]  <= req_wdata_q;
                     line_dirty[req_idx][req_off] <= 1'b1;
                     resp_rdata                   <= req_wdata_q;
                  end else begin
                     resp_rdata <= line_data[req_idx][req_off];
                  end
               end
            end
            S_WRITEBACK: line_dirty[req_idx] <= wb_remaining;
            S_FILL: begin
               for (int k = 0; k < 4; k++)
                  line_data[req_idx][k] <= readData[127-32*k -: 32];
               line_tag[req_idx]   <= req_tag;
               line_valid[req_idx] <= 1'b1;
               line_dirty[req_idx] <= 4'b0000;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_wb_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_cache_controller
// Purpose  : Self-checking bench for wb_cache_controller. A flat memory
//            array plays the main memory; a golden memory plus a tag/dirty
//            model predicts read data, hit/miss, latency and write-backs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_cache_controller;

   localparam int LINES = 4;
   localparam int CNT_W = 16;

   logic           clk;
   logic           rst_n;
   logic           req_valid;
   logic           req_ready;
   logic           req_write;
   logic [9:0]     req_addr;
   logic [31:0]    req_wdata;
   logic           resp_valid;
   logic [31:0]    resp_rdata;
   logic           isMemRead;
   logic           isLock;
   logic [9:0]     address;
   logic [127:0]   writeData;
   logic [3:0]     isDirty;
   logic [127:0]   readData;
   logic [CNT_W-1:0] hit_count;
   logic [CNT_W-1:0] miss_count;

   int tests_run = 0;
   int fails     = 0;

   // Main memory (written only from the stimulus process) and golden view
   logic [31:0] mem    [1024];
   logic [31:0] golden [1024];

   logic [9:0] mbase;
   assign mbase    = {address[9:2], 2'b00};
   assign readData = {mem[mbase], mem[mbase + 10'd1], mem[mbase + 10'd2], mem[mbase + 10'd3]};

   wb_cache_controller #(.LINES(LINES), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .isMemRead  (isMemRead),
      .isLock     (isLock),
      .address    (address),
      .writeData  (writeData),
      .isDirty    (isDirty),
      .readData   (readData),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit          m_valid [LINES];
   int          m_tag   [LINES];
   logic [3:0]  m_dirty [LINES];
   int          exp_hit;
   int          exp_miss;

   bit          e_hit;
   int          e_lat;
   logic [3:0]  e_vdirty;
   logic [9:0]  e_vbase;
   logic [9:0]  e_fbase;
   logic [31:0] e_rdata;

   task automatic model_reset();
      for (int i = 0; i < LINES; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 4'b0000;
         m_tag[i]   = 0;
      end
      exp_hit  = 0;
      exp_miss = 0;
      for (int j = 0; j < 1024; j++) golden[j] = mem[j];
   endtask

   task automatic model_apply(input bit wr, input int a, input logic [31:0] wd);
      int idx;
      int tag;
      idx      = (a / 4) % LINES;
      tag      = a / (4 * LINES);
      e_hit    = m_valid[idx] && (m_tag[idx] == tag);
      e_vdirty = (!e_hit && m_valid[idx]) ? m_dirty[idx] : 4'b0000;
      e_vbase  = 10'(m_tag[idx] * 4 * LINES + idx * 4);
      e_fbase  = 10'(tag * 4 * LINES + idx * 4);
      e_lat    = e_hit ? 2 : 4 + $countones(e_vdirty);
      if (e_hit) exp_hit++; else exp_miss++;
      if (!e_hit) begin
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tag;
         m_dirty[idx] = 4'b0000;
      end
      if (wr) begin
         golden[a]         = wd;
         m_dirty[idx][a % 4] = 1'b1;
      end
      e_rdata = golden[a];
   endtask

   // ---------------- driver / monitor ----------------
   int           obs_lat;
   logic [31:0]  obs_rdata;
   int           obs_nbeat;
   logic [9:0]   obs_baddr [8];
   logic [3:0]   obs_bdirty[8];
   logic [127:0] obs_bdata [8];
   int           obs_nfill;
   logic [9:0]   obs_faddr;
   bit           obs_ready_low;
   bit           obs_lock_low;
   bit           obs_timeout;

   task automatic mem_beat();
      int b;
      b = {address[9:2], 2'b00};
      for (int k = 0; k < 4; k++)
         if (isDirty[k]) mem[b + k] = writeData[127-32*k -: 32];
   endtask

   task automatic do_req(input bit wr, input logic [9:0] a, input logic [31:0] wd, input bit hold);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 64) begin @(negedge clk); n++; end
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_wdata = wd;
      @(posedge clk); #1;
      if (!hold) begin
         req_valid = 1'b0;
         req_write = 1'($urandom);
         req_addr  = 10'($urandom);
         req_wdata = $urandom;
      end
      obs_nbeat = 0; obs_nfill = 0; obs_faddr = '0;
      obs_ready_low = 1'b1; obs_lock_low = 1'b0;
      n = 1;
      while (!resp_valid && n < 64) begin
         if (req_ready) obs_ready_low = 1'b0;
         if (!isLock) obs_lock_low = 1'b1;
         if (!isLock && !isMemRead) begin
            if (obs_nbeat < 8) begin
               obs_baddr[obs_nbeat]  = address;
               obs_bdirty[obs_nbeat] = isDirty;
               obs_bdata[obs_nbeat]  = writeData;
            end
            obs_nbeat++;
            mem_beat();
         end
         if (!isLock && isMemRead) begin
            obs_nfill++;
            obs_faddr = address;
         end
         @(posedge clk); #1;
         n++;
      end
      if (req_ready) obs_ready_low = 1'b0;
      obs_timeout = !resp_valid;
      obs_lat     = n;
      obs_rdata   = resp_rdata;
      req_valid   = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      tests_run++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0) begin
         fails++; $display("FAIL reset_handshake: ready=%b valid=%b rdata=%h want 1 0 0", req_ready, resp_valid, resp_rdata);
      end
      tests_run++;
      if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
         fails++; $display("FAIL reset_counters: hit=%0d miss=%0d want 0 0", hit_count, miss_count);
      end
      tests_run++;
      if (isLock !== 1'b1 || isMemRead !== 1'b1 || address !== 10'd0 || isDirty !== 4'd0 || writeData !== 128'd0) begin
         fails++; $display("FAIL reset_mem_port: lock=%b rd=%b addr=%h dirty=%b want 1 1 0 0", isLock, isMemRead, address, isDirty);
      end
   endtask

   task automatic test_read_miss_hit();
      model_apply(1'b0, 0, 32'd0);
      do_req(1'b0, 10'd0, 32'd0, 1'b0);
      tests_run++;
      if (obs_rdata !== 32'h3cc3 || obs_lat != 4) begin
         fails++; $display("FAIL miss_read: rdata=%h lat=%0d want 3cc3 4", obs_rdata, obs_lat);
      end
      tests_run++;
      if (obs_nfill != 1 || obs_faddr !== 10'd0 || obs_nbeat != 0) begin
         fails++; $display("FAIL miss_fill: fills=%0d addr=%h beats=%0d want 1 0 0", obs_nfill, obs_faddr, obs_nbeat);
      end
      tests_run++;
      if (miss_count !== 16'd1 || hit_count !== 16'd0) begin
         fail_cnt_msg("miss_counters", 1, 0);
      end
      model_apply(1'b0, 0, 32'd0);
      do_req(1'b0, 10'd0, 32'd0, 1'b0);
      tests_run++;
      if (obs_rdata !== 32'h3cc3 || obs_lat != 2 || obs_lock_low) begin
         fails++; $display("FAIL hit_read: rdata=%h lat=%0d lock_dropped=%b want 3cc3 2 0", obs_rdata, obs_lat, obs_lock_low);
      end
      tests_run++;
      if (hit_count !== 16'd1 || miss_count !== 16'd1) begin
         fail_cnt_msg("hit_counters", 1, 1);
      end
   endtask

   task automatic fail_cnt_msg(input string nm, input int h, input int m);
      fails++;
      $display("FAIL %s: hit=%0d miss=%0d want hit=%0d miss=%0d", nm, hit_count, miss_count, h, m);
   endtask

   task automatic test_dirty_writeback();
      model_apply(1'b1, 1, 32'hAAAA5555);
      do_req(1'b1, 10'd1, 32'hAAAA5555, 1'b0);
      tests_run++;
      if (obs_rdata !== 32'hAAAA5555 || obs_lat != 2) begin
         fails++; $display("FAIL write_hit1: rdata=%h lat=%0d want aaaa5555 2", obs_rdata, obs_lat);
      end
      model_apply(1'b1, 3, 32'h00001234);
      do_req(1'b1, 10'd3, 32'h00001234, 1'b0);
      tests_run++;
      if (obs_rdata !== 32'h00001234 || obs_lat != 2) begin
         fails++; $display("FAIL write_hit3: rdata=%h lat=%0d want 1234 2", obs_rdata, obs_lat);
      end
      model_apply(1'b0, 512, 32'd0);
      do_req(1'b0, 10'd512, 32'd0, 1'b0);
      tests_run++;
      if (obs_nbeat != 2) begin
         fails++; $display("FAIL wb_beats: got %0d want 2", obs_nbeat);
      end else begin
         tests_run++;
         if (obs_baddr[0] !== 10'd0 || obs_bdirty[0] !== 4'b0010 || obs_bdata[0] !== {4{32'hAAAA5555}}) begin
            fails++; $display("FAIL wb_beat0: addr=%h dirty=%b data=%h want 0 0010 aaaa5555x4", obs_baddr[0], obs_bdirty[0], obs_bdata[0]);
         end
         tests_run++;
         if (obs_baddr[1] !== 10'd0 || obs_bdirty[1] !== 4'b1000 || obs_bdata[1] !== {4{32'h00001234}}) begin
            fails++; $display("FAIL wb_beat1: addr=%h dirty=%b data=%h want 0 1000 1234x4", obs_baddr[1], obs_bdirty[1], obs_bdata[1]);
         end
      end
      tests_run++;
      if (obs_rdata !== 32'h00000ccc || obs_lat != 6 || obs_faddr !== 10'd512) begin
         fails++; $display("FAIL dirty_miss: rdata=%h lat=%0d fill=%h want ccc 6 200", obs_rdata, obs_lat, obs_faddr);
      end
   endtask

   task automatic test_clean_evict();
      model_apply(1'b0, 768, 32'd0);
      do_req(1'b0, 10'd768, 32'd0, 1'b0);
      tests_run++;
      if (obs_rdata !== 32'h000000c3 || obs_nbeat != 0 || obs_lat != 4) begin
         fails++; $display("FAIL clean_evict: rdata=%h beats=%0d lat=%0d want c3 0 4", obs_rdata, obs_nbeat, obs_lat);
      end
      model_apply(1'b0, 1, 32'd0);
      do_req(1'b0, 10'd1, 32'd0, 1'b0);
      tests_run++;
      if (obs_rdata !== 32'hAAAA5555) begin
         fails++; $display("FAIL readback1: got %h want aaaa5555", obs_rdata);
      end
      model_apply(1'b0, 3, 32'd0);
      do_req(1'b0, 10'd3, 32'd0, 1'b0);
      tests_run++;
      if (obs_rdata !== 32'h00001234 || obs_lat != 2) begin
         fails++; $display("FAIL readback3: rdata=%h lat=%0d want 1234 2", obs_rdata, obs_lat);
      end
   endtask

   task automatic test_write_miss_hold();
      bit extra;
      model_apply(1'b1, 5, 32'hDEADBEEF);
      do_req(1'b1, 10'd5, 32'hDEADBEEF, 1'b1);
      tests_run++;
      if (obs_rdata !== 32'hDEADBEEF || obs_faddr !== 10'd4 || obs_nfill != 1 || obs_lat != 4) begin
         fails++; $display("FAIL write_miss: rdata=%h fill=%h fills=%0d lat=%0d want deadbeef 4 1 4", obs_rdata, obs_faddr, obs_nfill, obs_lat);
      end
      tests_run++;
      if (!obs_ready_low) begin
         fails++; $display("FAIL hold_ready: got ready high while busy, want 0");
      end
      extra = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (resp_valid || !req_ready) extra = 1'b1;
      end
      tests_run++;
      if (extra) begin
         fails++; $display("FAIL hold_single_accept: got extra activity after resp, want none");
      end
      tests_run++;
      if (hit_count !== 16'(exp_hit) || miss_count !== 16'(exp_miss)) fail_cnt_msg("hold_counters", exp_hit, exp_miss);
   endtask

   task automatic test_random();
      bit         wr;
      int         a;
      logic [31:0] wd;
      int         bi;
      for (int t = 0; t < 200; t++) begin
         wr = 1'($urandom_range(0, 1));
         a  = ({$urandom_range(0, 3)} * 13 % 64) * 16 + $urandom_range(0, 15);
         wd = $urandom;
         model_apply(wr, a, wd);
         do_req(wr, 10'(a), wd, 1'b0);
         tests_run++;
         if (obs_timeout || obs_rdata !== e_rdata || obs_lat != e_lat) begin
            fails++; $display("FAIL rand_resp[%0d]: addr=%h rdata=%h lat=%0d want %h %0d", t, a, obs_rdata, obs_lat, e_rdata, e_lat);
         end
         tests_run++;
         if (obs_nbeat != $countones(e_vdirty) || obs_nfill != (e_hit ? 0 : 1) || (!e_hit && obs_faddr !== e_fbase)) begin
            fails++; $display("FAIL rand_mem[%0d]: beats=%0d fills=%0d fill=%h want %0d %0d %h", t, obs_nbeat, obs_nfill, obs_faddr, $countones(e_vdirty), e_hit ? 0 : 1, e_fbase);
         end
         bi = 0;
         for (int k = 0; k < 4; k++) begin
            if (e_vdirty[k]) begin
               if (bi < obs_nbeat && bi < 8) begin
                  tests_run++;
                  if (obs_baddr[bi] !== e_vbase || obs_bdirty[bi] !== (4'b0001 << k) || obs_bdata[bi] !== {4{golden[e_vbase + k]}}) begin
                     fails++; $display("FAIL rand_beat[%0d.%0d]: addr=%h dirty=%b data=%h want %h word %0d %h", t, bi, obs_baddr[bi], obs_bdirty[bi], obs_bdata[bi], e_vbase, k, golden[e_vbase + k]);
                  end
               end
               bi++;
            end
         end
         tests_run++;
         if (!obs_ready_low || hit_count !== 16'(exp_hit) || miss_count !== 16'(exp_miss)) begin
            fails++; $display("FAIL rand_state[%0d]: ready_low=%b hit=%0d miss=%0d want 1 %0d %0d", t, obs_ready_low, hit_count, miss_count, exp_hit, exp_miss);
         end
      end
   endtask

   task automatic test_reset_mid_fill();
      int  t;
      int  n;
      bit  found;
      t = m_valid[0] ? (m_tag[0] + 1) % 64 : 5;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 64) begin @(negedge clk); n++; end
      req_valid = 1'b1; req_write = 1'b0; req_addr = 10'(t * 16); req_wdata = '0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      found = 1'b0;
      n = 0;
      while (!found && n < 40) begin
         if (!isLock && isMemRead) found = 1'b1;
         else begin
            if (!isLock && !isMemRead) mem_beat();
            @(posedge clk); #1;
            n++;
         end
      end
      tests_run++;
      if (!found) begin
         fails++; $display("FAIL midfill_reach: got no FILL cycle within 40 cycles, want one");
      end
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      tests_run++;
      if (req_ready !== 1'b1 || isLock !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0) begin
         fails++; $display("FAIL midfill_idle: ready=%b lock=%b valid=%b rdata=%h want 1 1 0 0", req_ready, isLock, resp_valid, resp_rdata);
      end
      tests_run++;
      if (hit_count !== 16'd0 || miss_count !== 16'd0) fail_cnt_msg("midfill_counters", 0, 0);
      model_apply(1'b0, 0, 32'd0);
      do_req(1'b0, 10'd0, 32'd0, 1'b0);
      tests_run++;
      if (obs_rdata !== e_rdata || obs_lat != 4 || miss_count !== 16'd1 || hit_count !== 16'd0) begin
         fails++; $display("FAIL post_reset_miss: rdata=%h lat=%0d miss=%0d hit=%0d want %h 4 1 0", obs_rdata, obs_lat, miss_count, hit_count, e_rdata);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[0]   = 32'h00003cc3;
      mem[512] = 32'h00000ccc;
      mem[768] = 32'h000000c3;
      test_reset();
      test_read_miss_hit();
      test_dirty_writeback();
      test_clean_evict();
      test_write_miss_hold();
      test_random();
      test_reset_mid_fill();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
`default_nettype wire
